match_remap_ctrl: RTL

Parametrised, registered successor to the crossbar's combinational initiator-swap logic. It sits between the address decoders and the arbitration tree of the AXI node, and rewrites per-region initiator match vectors through a programmable table of remap entries. Each entry is either move or copy. The table is double-buffered: software writes a shadow copy, and a commit swaps it in only once the affected initiators have drained, or fails with an error after a timeout.

---
 rtl/match_remap_pkg.sv | 38 +++
 rtl/match_remap_core.sv | 46 ++++
 rtl/match_remap_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/match_remap_pkg.sv
// Shared types and helpers for the initiator match-vector remapper.
// Latency: none, declarations only.
// Backpressure: not applicable.
package match_remap_pkg;

   // Port index fields are stored at a fixed width so one entry type serves every port count.
   // The top zero-extends its narrower configuration indices into these fields.
   localparam int unsigned IDX_W = 8;

   typedef enum logic {
      MOVE = 1'b0,
      COPY = 1'b1
   } mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   typedef struct packed {
      logic             en;
      mode_e            mode;
      logic [IDX_W-1:0] source;
      logic [IDX_W-1:0] target;
   } entry_t;

   // An entry takes part only when it is enabled and both indices name a real port.
   function automatic logic entry_legal(input entry_t e, input int unsigned n_port);
      return e.en && (32'(e.source) < n_port) && (32'(e.target) < n_port);
   endfunction

   // True when a legal entry uses port p as either its source or its target.
   function automatic logic entry_touches(input entry_t e, input int unsigned n_port,
                                          input int unsigned p);
      return entry_legal(e, n_port) && ((32'(e.source) == p) || (32'(e.target) == p));
   endfunction

endpackage

// File: rtl/match_remap_core.sv
// Remaps one region's initiator match vector through a table of move/copy entries.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module match_remap_core
   import match_remap_pkg::*;
#(
   parameter int unsigned N_INIT_PORT = 8,
   parameter int unsigned N_ENTRY     = 4
) (
   input  logic   [N_INIT_PORT-1:0] match_i,
   input  entry_t [N_ENTRY-1:0]     entries_i,
   output logic   [N_INIT_PORT-1:0] match_o
);

   logic [N_INIT_PORT-1:0] set_vec;
   logic [N_INIT_PORT-1:0] clr_vec;
   logic                   src_hit;

   // Every entry reads the raw input, so entries never chain; set wins over clear below.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      src_hit = 1'b0;
      for (int unsigned e = 0; e < N_ENTRY; e++) begin
         src_hit = 1'b0;
         if (entry_legal(entries_i[e], N_INIT_PORT)) begin
            for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
               if (32'(entries_i[e].source) == p) begin
                  src_hit = match_i[p];
                  if (entries_i[e].mode == MOVE) begin
                     clr_vec[p] = 1'b1;
                  end
               end
            end
            for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
               if ((32'(entries_i[e].target) == p) && src_hit) begin
                  set_vec[p] = 1'b1;
               end
            end
         end
      end
   end

   assign match_o = (match_i & ~clr_vec) | set_vec;

endmodule

// File: rtl/match_remap_ctrl.sv
// Double-buffered remap table with drain-gated commit, feeding registered remapped match vectors.
// Latency: 1 cycle input to output; commit with no drain wait reaches the output 3 cycles after commit_i.
// Backpressure: cfg_ready_o drops while a commit drains; commit_i is ignored during a drain.
module match_remap_ctrl
   import match_remap_pkg::*;
#(
   parameter int unsigned N_INIT_PORT = 8,
   parameter int unsigned N_REGION    = 3,
   parameter int unsigned LOG_N_INIT  = 3,
   parameter int unsigned N_ENTRY     = 4,
   parameter int unsigned TIMEOUT_W   = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [N_REGION-1:0][N_INIT_PORT-1:0]   match_region_int_i,
   output logic [N_REGION-1:0][N_INIT_PORT-1:0]   match_region_int_o,
   input  logic [N_INIT_PORT-1:0]                 port_busy_i,
   input  logic                                   cfg_valid_i,
   output logic                                   cfg_ready_o,
   input  logic [$clog2(N_ENTRY)-1:0]             cfg_entry_i,
   input  logic                                   cfg_en_i,
   input  logic                                   cfg_mode_i,
   input  logic [LOG_N_INIT-1:0]                  cfg_source_i,
   input  logic [LOG_N_INIT-1:0]                  cfg_target_i,
   input  logic                                   commit_i,
   output logic                                   commit_pending_o,
   output logic                                   commit_done_o,
   output logic                                   commit_err_o
);

   state_e                               state_q, state_d;
   logic   [TIMEOUT_W-1:0]               cnt_q, cnt_d;
   entry_t [N_ENTRY-1:0]                 active_q, active_d;
   entry_t [N_ENTRY-1:0]                 shadow_q, shadow_d;
   logic   [N_REGION-1:0][N_INIT_PORT-1:0] out_q;
   logic   [N_REGION-1:0][N_INIT_PORT-1:0] remap_region;
   logic                                 done_q, done_d;
   logic                                 err_q, err_d;
   logic   [N_INIT_PORT-1:0]             affected;
   entry_t                               cfg_wr;

   assign cfg_wr = '{en:     cfg_en_i,
                     mode:   mode_e'(cfg_mode_i),
                     source: IDX_W'(cfg_source_i),
                     target: IDX_W'(cfg_target_i)};

   // One combinational remapper per region, all driven by the active table.
   for (genvar r = 0; r < N_REGION; r++) begin : g_region
      match_remap_core #(
         .N_INIT_PORT (N_INIT_PORT),
         .N_ENTRY     (N_ENTRY)
      ) u_core (
         .match_i   (match_region_int_i[r]),
         .entries_i (active_q),
         .match_o   (remap_region[r])
      );
   end

   // Ports touched by either the old or the new table must be quiet before the swap.
   always_comb begin
      affected = '0;
      for (int unsigned e = 0; e < N_ENTRY; e++) begin
         for (int unsigned p = 0; p < N_INIT_PORT; p++) begin
            if (entry_touches(active_q[e], N_INIT_PORT, p) ||
                entry_touches(shadow_q[e], N_INIT_PORT, p)) begin
               affected[p] = 1'b1;
            end
         end
      end
   end

   // Commit FSM: shadow writes and commit requests in IDLE, drain-or-timeout in DRAIN.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      shadow_d = shadow_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A write in the commit cycle lands in the shadow before DRAIN reads it.
            if (cfg_valid_i) begin
               shadow_d[cfg_entry_i] = cfg_wr;
            end
            if (commit_i) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
         end
         DRAIN: begin
            if ((port_busy_i & affected) == '0) begin
               active_d = shadow_q;
               state_d  = IDLE;
               done_d   = 1'b1;
            end else if (cnt_q == '1) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, tables, status pulses and the registered remapped output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         active_q <= '0;
         shadow_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         shadow_q <= shadow_d;
         done_q   <= done_d;
         err_q    <= err_d;
         out_q    <= remap_region;
      end
   end

   assign match_region_int_o = out_q;
   assign cfg_ready_o        = (state_q == IDLE);
   assign commit_pending_o   = (state_q == DRAIN);
   assign commit_done_o      = done_q;
   assign commit_err_o       = err_q;

endmodule
